rv32m_mul_sequencer: RTL and testbench

- Sits between the core's M-extension issue logic and the multiplier (multiplier_top).
- Accepts MUL/MULH/MULHSU/MULHU requests over a valid/ready handshake and decodes funct3 into the multiplier's sign and upper controls. Starts the multiplier, waits for its done pulse, then returns a tagged result over a second valid/ready handshake.
- Adds a one-entry result cache, flush/drain handling, a watchdog timeout, and error responses for unsupported funct3 values.

---
 rtl/rv32m_pkg.sv | 52 +++++
 rtl/rv32m_mul_result_cache.sv | 46 ++++
 rtl/rv32m_mul_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_rv32m_mul_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// ============================================================================
// Module : rv32m_pkg
// Brief  : Shared funct3 codes, FSM states and decoded-control types for the
//          RV32M multiply sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv32m_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic signed_a;
        logic signed_b;
        logic upper;
    } mul_ctrl_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } cache_key_t;

    // Unsupported encodings (1xx) decode to all-zero controls.
    function automatic mul_ctrl_t decode_funct3(input logic [2:0] f3);
        mul_ctrl_t c;
        c = '0;
        case (f3)
            F3_MUL:    c = '{signed_a: 1'b0, signed_b: 1'b0, upper: 1'b0};
            F3_MULH:   c = '{signed_a: 1'b1, signed_b: 1'b1, upper: 1'b1};
            F3_MULHSU: c = '{signed_a: 1'b1, signed_b: 1'b0, upper: 1'b1};
            F3_MULHU:  c = '{signed_a: 1'b0, signed_b: 1'b0, upper: 1'b1};
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32m_mul_result_cache.sv
// ============================================================================
// Module : rv32m_mul_result_cache
// Brief  : One-entry {funct3,rs1,rs2} -> result cache with load/invalidate.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv32m_mul_result_cache
    import rv32m_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  cache_key_t  lookup_key_i,
    output logic        hit_o,
    output logic [31:0] hit_result_o,
    input  logic        load_i,
    input  cache_key_t  load_key_i,
    input  logic [31:0] load_result_i,
    input  logic        inval_i
);

    logic        valid_q;
    cache_key_t  key_q;
    logic [31:0] result_q;

    // Invalidate wins over load so a flushed/expired result is never retained.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q  <= 1'b0;
            key_q    <= '0;
            result_q <= '0;
        end else if (inval_i) begin
            valid_q  <= 1'b0;
        end else if (load_i) begin
            valid_q  <= 1'b1;
            key_q    <= load_key_i;
            result_q <= load_result_i;
        end
    end

    assign hit_o        = valid_q && (key_q == lookup_key_i);
    assign hit_result_o = result_q;

endmodule

`default_nettype wire

// File: rtl/rv32m_mul_sequencer.sv
// ============================================================================
// Module : rv32m_mul_sequencer
// Brief  : Issues RV32M MUL* ops to the multiplier and returns tagged results,
//          with result cache, flush/drain and a watchdog.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv32m_mul_sequencer
    import rv32m_pkg::*;
#(
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_funct3_i,
    input  logic [31:0]      req_rs1_i,
    input  logic [31:0]      req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             flush_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_error_o,
    output logic             busy_o,
    output logic             mult_en_o,
    output logic [31:0]      op_A_o,
    output logic [31:0]      op_B_o,
    output logic             signed_A_o,
    output logic             signed_B_o,
    output logic             upper_o,
    input  logic [31:0]      mult_result_i,
    input  logic             mult_done_i
);

    localparam int             WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [31:0]       opa_q, opa_d;
    logic [31:0]       opb_q, opb_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [2:0]        f3_q, f3_d;
    mul_ctrl_t         ctrl_q, ctrl_d;
    logic [31:0]       result_q, result_d;
    logic              error_q, error_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    logic        req_ready;
    logic        cache_hit;
    logic [31:0] cache_result;
    logic        cache_load;
    logic        cache_inval;
    cache_key_t  lookup_key;
    cache_key_t  load_key;

    assign req_ready  = (state_q == ST_IDLE) && rst_i && !flush_i;
    assign lookup_key = {req_funct3_i, req_rs1_i, req_rs2_i};
    assign load_key   = {f3_q, opa_q, opb_q};

    rv32m_mul_result_cache u_cache (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .lookup_key_i  (lookup_key),
        .hit_o         (cache_hit),
        .hit_result_o  (cache_result),
        .load_i        (cache_load),
        .load_key_i    (load_key),
        .load_result_i (mult_result_i),
        .inval_i       (cache_inval)
    );

    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        tag_d       = tag_q;
        f3_d        = f3_q;
        ctrl_d      = ctrl_q;
        result_d    = result_q;
        error_d     = error_q;
        wdog_d      = wdog_q;
        cache_load  = 1'b0;
        cache_inval = flush_i;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready) begin
                    opa_d  = req_rs1_i;
                    opb_d  = req_rs2_i;
                    tag_d  = req_tag_i;
                    f3_d   = req_funct3_i;
                    ctrl_d = decode_funct3(req_funct3_i);
                    if (req_funct3_i[2]) begin
                        state_d  = ST_RESP;
                        result_d = '0;
                        error_d  = 1'b1;
                    end else if (cache_hit) begin
                        state_d  = ST_RESP;
                        result_d = cache_result;
                        error_d  = 1'b0;
                    end else begin
                        state_d  = ST_START;
                        result_d = '0;
                        error_d  = 1'b0;
                    end
                end
            end
            ST_START: begin
                wdog_d  = '0;
                state_d = flush_i ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush_i) begin
                    // A coincident done pulse is the drain itself.
                    state_d = mult_done_i ? ST_IDLE : ST_DRAIN;
                    wdog_d  = '0;
                end else if (mult_done_i) begin
                    result_d   = mult_result_i;
                    error_d    = 1'b0;
                    cache_load = 1'b1;
                    state_d    = ST_RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    result_d    = '0;
                    error_d     = 1'b1;
                    cache_inval = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (mult_done_i || (wdog_q == WDOG_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            tag_q    <= '0;
            f3_q     <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            tag_q    <= tag_d;
            f3_q     <= f3_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            error_q  <= error_d;
            wdog_q   <= wdog_d;
        end
    end

    // Every output is forced low while reset is held, not just after the edge.
    assign req_ready_o  = req_ready;
    assign rsp_valid_o  = rst_i && (state_q == ST_RESP);
    assign busy_o       = rst_i && (state_q != ST_IDLE);
    assign mult_en_o    = rst_i && (state_q == ST_START);
    assign rsp_result_o = rst_i ? result_q : '0;
    assign rsp_tag_o    = rst_i ? tag_q : '0;
    assign rsp_error_o  = rst_i && error_q;
    assign op_A_o       = rst_i ? opa_q : '0;
    assign op_B_o       = rst_i ? opb_q : '0;
    assign signed_A_o   = rst_i && ctrl_q.signed_a;
    assign signed_B_o   = rst_i && ctrl_q.signed_b;
    assign upper_o      = rst_i && ctrl_q.upper;

endmodule

`default_nettype wire

// File: tb/tb_rv32m_mul_sequencer.sv
// ============================================================================
// Module : tb_rv32m_mul_sequencer
// Brief  : Directed + random bench with a multiplier model and reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rv32m_mul_sequencer;

    localparam int TAG_W = 5;
    localparam int TO    = 64;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       req_funct3_i;
    logic [31:0]      req_rs1_i;
    logic [31:0]      req_rs2_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             flush_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_result_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             rsp_error_o;
    logic             busy_o;
    logic             mult_en_o;
    logic [31:0]      op_A_o;
    logic [31:0]      op_B_o;
    logic             signed_A_o;
    logic             signed_B_o;
    logic             upper_o;
    logic [31:0]      mult_result_i;
    logic             mult_done_i;

    always #5 clk_i = ~clk_i;

    rv32m_mul_sequencer #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct3_i(req_funct3_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .req_tag_i(req_tag_i), .flush_i(flush_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o), .rsp_error_o(rsp_error_o),
        .busy_o(busy_o), .mult_en_o(mult_en_o),
        .op_A_o(op_A_o), .op_B_o(op_B_o),
        .signed_A_o(signed_A_o), .signed_B_o(signed_B_o), .upper_o(upper_o),
        .mult_result_i(mult_result_i), .mult_done_i(mult_done_i)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Full 64-bit product of the sign/zero-extended operands.
    function automatic logic [63:0] prod64(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
        logic [63:0] ea, eb;
        ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] s;
        logic [63:0] u;
        case (f3)
            3'b000: begin u = {32'b0, a} * {32'b0, b}; return u[31:0]; end
            3'b001: begin s = $signed(a) * $signed(b); return s[63:32]; end
            3'b010: begin s = $signed(a) * $signed({1'b0, b}); return s[63:32]; end
            3'b011: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [2:0] ref_ctrl(input logic [2:0] f3);
        case (f3)
            3'b001:  return 3'b111;
            3'b010:  return 3'b101;
            3'b011:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Multiplier model: done pulse mul_lat cycles after the start cycle.
    int          mul_lat    = 3;
    bit          mul_hang   = 0;
    bit          inject_done = 0;
    int          en_cycles  = 0;
    logic [31:0] cap_a, cap_b;
    logic [2:0]  cap_ctrl;
    logic [63:0] p;

    always @(negedge clk_i) if (mult_en_o) en_cycles++;

    initial begin
        mult_done_i   = 1'b0;
        mult_result_i = 32'h0;
        forever begin
            @(posedge clk_i);
            #1;
            if (inject_done) begin
                inject_done   = 0;
                mult_result_i = 32'hDEAD_BEEF;
                mult_done_i   = 1'b1;
                @(posedge clk_i);
                #1;
                mult_done_i   = 1'b0;
            end else if (mult_en_o) begin
                cap_a    = op_A_o;
                cap_b    = op_B_o;
                cap_ctrl = {signed_A_o, signed_B_o, upper_o};
                p        = prod64(op_A_o, op_B_o, signed_A_o, signed_B_o);
                if (!mul_hang) begin
                    repeat (mul_lat) @(posedge clk_i);
                    #1;
                    mult_result_i = cap_ctrl[0] ? p[63:32] : p[31:0];
                    mult_done_i   = 1'b1;
                    @(posedge clk_i);
                    #1;
                    mult_done_i   = 1'b0;
                end
            end
        end
    end

    // Reference cache state.
    bit          ref_cv = 0;
    logic [66:0] ref_key;
    logic [31:0] ref_res;

    task automatic do_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input int lat, input int stall,
                          input bit hang);
        bit          exp_err, exp_hit, exp_mul;
        logic [31:0] exp_res, hold_res;
        int          exp_lat, en0, n;
        exp_hit = !f3[2] && ref_cv && (ref_key == {f3, a, b});
        exp_mul = !f3[2] && !exp_hit;
        exp_err = f3[2] || (exp_mul && hang);
        exp_res = exp_err ? 32'h0 : (exp_hit ? ref_res : ref_mul(f3, a, b));
        exp_lat = !exp_mul ? 1 : (hang ? TO + 2 : lat + 2);
        en0      = en_cycles;
        mul_lat  = lat;
        mul_hang = hang;
        req_valid_i  = 1'b1;
        req_funct3_i = f3;
        req_rs1_i    = a;
        req_rs2_i    = b;
        req_tag_i    = tag;
        check("req_ready_idle", {63'b0, req_ready_o}, 64'd1);
        step();
        req_valid_i = 1'b0;
        req_rs1_i   = $urandom;
        n = 1;
        while (!rsp_valid_o && n < 200) begin
            step();
            n++;
        end
        check("rsp_latency", 64'(n), 64'(exp_lat));
        check("rsp_result", {32'b0, rsp_result_o}, {32'b0, exp_res});
        check("rsp_tag", {59'b0, rsp_tag_o}, {59'b0, tag});
        check("rsp_error", {63'b0, rsp_error_o}, {63'b0, exp_err});
        check("mult_en_cycles", 64'(en_cycles - en0), exp_mul ? 64'd1 : 64'd0);
        if (exp_mul) begin
            check("mult_ctrl", {61'b0, cap_ctrl}, {61'b0, ref_ctrl(f3)});
            check("mult_ops", {cap_a, cap_b}, {a, b});
        end
        hold_res = rsp_result_o;
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_valid", {63'b0, rsp_valid_o}, 64'd1);
            check("stall_result", {32'b0, rsp_result_o}, {32'b0, hold_res});
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        check("idle_after_rsp", {62'b0, busy_o, rsp_valid_o}, 64'd0);
        if (exp_mul && !hang) begin
            ref_cv  = 1;
            ref_key = {f3, a, b};
            ref_res = exp_res;
        end
        if (exp_mul && hang) ref_cv = 0;
        mul_hang = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {req_ready_o, rsp_valid_o, rsp_error_o, busy_o, mult_en_o,
                    signed_A_o, signed_B_o, upper_o, rsp_tag_o, 51'b0}, 64'd0);
        check({tag, "_data"}, {op_A_o | op_B_o, rsp_result_o}, 64'd0);
    endtask

    initial begin
        int n;
        bit saw_rsp;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [31:0] pool [4];
        pool = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};

        rst_i = 1'b0; req_valid_i = 1'b0; req_funct3_i = '0; req_rs1_i = '0;
        req_rs2_i = '0; req_tag_i = '0; flush_i = 1'b0; rsp_ready_i = 1'b0;
        repeat (3) step();
        check_all_zero("reset_outputs");
        rst_i = 1'b1;
        #1;
        check("ready_after_reset", {63'b0, req_ready_o}, 64'd1);

        // MULH miss, then identical hit, then MULHU miss.
        do_req(3'b001, 32'hFFFF_FFFF, 32'h2, 5'd7, 10, 0, 0);
        check("mulh_value", {32'b0, rsp_result_o}, 64'hFFFF_FFFF);
        do_req(3'b001, 32'hFFFF_FFFF, 32'h2, 5'd7, 10, 0, 0);
        do_req(3'b011, 32'hFFFF_FFFF, 32'h2, 5'd8, 5, 0, 0);
        check("mulhu_value", {32'b0, rsp_result_o}, 64'h1);
        do_req(3'b100, 32'h5, 32'h6, 5'd9, 3, 0, 0);

        // Flush three cycles into WAIT; drain until the late done.
        mul_lat = 10;
        req_valid_i = 1'b1; req_funct3_i = 3'b000; req_rs1_i = 32'd11;
        req_rs2_i = 32'd13; req_tag_i = 5'd3;
        step();
        req_valid_i = 1'b0;
        repeat (3) step();
        flush_i = 1'b1;
        #1;
        check("ready_low_on_flush", {63'b0, req_ready_o}, 64'd0);
        step();
        flush_i = 1'b0;
        ref_cv  = 0;
        n = 0;
        saw_rsp = 0;
        while (busy_o && n < 100) begin
            if (rsp_valid_o) saw_rsp = 1;
            step();
            n++;
        end
        check("drain_cycles", 64'(n), 64'd7);
        check("drain_no_rsp", {63'b0, saw_rsp}, 64'd0);
        do_req(3'b001, 32'hFFFF_FFFF, 32'h2, 5'd7, 4, 0, 0);
        do_req(3'b000, 32'd11, 32'd13, 5'd3, 2, 0, 0);

        // Watchdog timeout, then a late done in IDLE.
        do_req(3'b000, 32'd3, 32'd5, 5'd12, 4, 0, 1);
        inject_done = 1;
        repeat (3) step();
        check("late_done_ignored", {62'b0, busy_o, rsp_valid_o}, 64'd0);
        do_req(3'b000, 32'd3, 32'd5, 5'd12, 4, 0, 0);

        // Response stall, then reset mid-WAIT.
        do_req(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 4, 5, 0);
        mul_lat = 10;
        req_valid_i = 1'b1; req_funct3_i = 3'b011; req_rs1_i = 32'h77;
        req_rs2_i = 32'h99; req_tag_i = 5'd30;
        step();
        req_valid_i = 1'b0;
        repeat (3) step();
        rst_i = 1'b0;
        #1;
        check("reset_gates_outputs", {61'b0, rsp_valid_o, busy_o, req_ready_o}, 64'd0);
        step();
        check_all_zero("midwait_reset");
        rst_i  = 1'b1;
        ref_cv = 0;
        repeat (15) step();
        check("idle_after_reset", {62'b0, busy_o, rsp_valid_o}, 64'd0);

        // Random traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            if (t == 0 || $urandom_range(0, 9) > 2) begin
                f3 = 3'($urandom_range(0, 7));
                a  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom;
                b  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom;
            end
            do_req(f3, a, b, 5'($urandom), $urandom_range(1, 6), $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
